alu_seq: RTL

Parametrised, handshaked ALU: the sequential successor to the team's 8-bit combinational ALU. It registers every result with a valid/ready handshake and keeps a carry flag between operations for multi-word ADC/SBB chains. It adds arithmetic shift, unsigned compare and an iterative shift-add multiplier. It sits between an instruction/operand source and a writeback consumer, and both sides may stall.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 65 ++++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and
// the shift-amount width helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_ADC   = 4'd9;
  localparam logic [3:0] OP_SBB   = 4'd10;
  localparam logic [3:0] OP_SLTU  = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_MULHU = 4'd13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic int sw_of(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle; done is high
// during the final iteration and product already includes that last step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == CW'(1));
  assign product  = acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a};
      acc_d    = '0;
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with a persistent carry for ADC/SBB chains and an
// optional iterative multiplier. Both sides use valid/ready: a beat transfers
// on a rising edge where valid and ready are both high.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output state_e           dbg_state
);

  localparam int SW = sw_of(WIDTH);

  state_e             state_q, state_d;
  logic               c_q, c_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic               mul_hi_q, mul_hi_d;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic               is_mul, accept, cin, sh_big;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     add_s, sub_s, add_x, sub_x;
  logic [WIDTH-1:0]   alu_res, mul_res;
  logic               alu_c, alu_ovf;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && ((op == OP_MUL) || (op == OP_MULHU));
  assign cin       = ((op == OP_ADC) || (op == OP_SBB)) && c_q;
  assign shamt     = b[SW-1:0];
  assign sh_big    = (int'(shamt) >= WIDTH);

  // Unsigned forms give carry/borrow in the top bit; sign-extended forms give
  // overflow as a disagreement between the top two bits.
  assign add_s = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  assign sub_s = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
  assign add_x = {a[WIDTH-1], a} + {b[WIDTH-1], b} + (WIDTH+1)'(cin);
  assign sub_x = {a[WIDTH-1], a} - {b[WIDTH-1], b} - (WIDTH+1)'(cin);

  always_comb begin
    alu_res = '0;
    alu_c   = c_q;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c   = add_s[WIDTH];
        alu_ovf = add_x[WIDTH] ^ add_x[WIDTH-1];
      end
      OP_SUB, OP_SBB: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c   = sub_s[WIDTH];
        alu_ovf = sub_x[WIDTH] ^ sub_x[WIDTH-1];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = sh_big ? '0 : (a << shamt);
      OP_SHR:  alu_res = sh_big ? '0 : (a >> shamt);
      OP_SRA:  alu_res = sh_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  assign mul_res = mul_hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    mul_hi_d    = mul_hi_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            mul_hi_d  = (op == OP_MULHU);
            state_d   = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            neg_d       = alu_res[WIDTH-1];
            ovf_d       = alu_ovf;
            c_d         = alu_c;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          out_valid_d = 1'b1;
          result_d    = mul_res;
          zero_d      = (mul_res == '0);
          neg_d       = mul_res[WIDTH-1];
          ovf_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      mul_hi_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      mul_hi_q    <= mul_hi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = c_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule
